// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-miss, D-miss and D write-through requests onto one memory port and streams miss blocks into the caches.
// Optional fill statistics counters are enabled by defining MEM_FILL_ARBITER_STATS_EN.
module mem_fill_arbiter #(
    parameter int  BLK_WORDS = 8,
    localparam int WIDX_W    = $clog2(BLK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [15:0]       i_miss_addr,
    input  logic              d_miss,
    input  logic [15:0]       d_miss_addr,
    input  logic              d_wr_req,
    input  logic [15:0]       d_wr_addr,
    input  logic [15:0]       d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       fill_data,
    output logic [WIDX_W-1:0] fill_widx,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
`ifdef MEM_FILL_ARBITER_STATS_EN
    ,
    output logic [15:0]       i_fill_cnt,
    output logic [15:0]       d_fill_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    localparam logic [15:0]       BASE_MASK = ~16'((2 * BLK_WORDS) - 1);
    localparam logic [WIDX_W:0]   ISS_END   = (WIDX_W + 1)'(BLK_WORDS);
    localparam logic [WIDX_W:0]   ISS_ONE   = (WIDX_W + 1)'(1);
    localparam logic [WIDX_W-1:0] RCV_LAST  = WIDX_W'(BLK_WORDS - 1);
    localparam logic [WIDX_W-1:0] RCV_ONE   = WIDX_W'(1);

    state_t            state_q, state_d;
    logic              own_d_q, own_d_d;   // 1 = current fill belongs to the D-cache
    logic [15:0]       base_q, base_d;
    logic [WIDX_W:0]   iss_q, iss_d;
    logic [WIDX_W-1:0] rcv_q, rcv_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_d_q <= 1'b0;
            base_q  <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
        end else begin
            state_q <= state_d;
            own_d_q <= own_d_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        own_d_d     = own_d_q;
        base_d      = base_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_widx   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                iss_d = '0;
                rcv_d = '0;
                if (d_wr_req) begin
                    state_d = WRITE;
                end else if (d_miss) begin
                    state_d = FILL;
                    own_d_d = 1'b1;
                    base_d  = d_miss_addr & BASE_MASK;
                end else if (i_miss) begin
                    state_d = FILL;
                    own_d_d = 1'b0;
                    base_d  = i_miss_addr & BASE_MASK;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_done = 1'b1;
                state_d   = IDLE;
            end
            FILL: begin
                if (iss_q < ISS_END) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q | {{(15 - WIDX_W){1'b0}}, iss_q[WIDX_W-1:0], 1'b0};
                    iss_d    = iss_q + ISS_ONE;
                end
                // Read data returns in issue order, so the receive count is the word index.
                if (mem_rvalid) begin
                    fill_data = mem_rdata;
                    fill_widx = rcv_q;
                    d_fill_we = own_d_q;
                    i_fill_we = !own_d_q;
                    rcv_d     = rcv_q + RCV_ONE;
                    if (rcv_q == RCV_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                d_fill_done = own_d_q;
                i_fill_done = !own_d_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_FILL_ARBITER_STATS_EN
    logic [15:0] i_fill_cnt_q, d_fill_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_fill_cnt_q <= '0;
            d_fill_cnt_q <= '0;
        end else begin
            if (i_fill_done && (i_fill_cnt_q != 16'hFFFF)) begin
                i_fill_cnt_q <= i_fill_cnt_q + 16'd1;
            end
            if (d_fill_done && (d_fill_cnt_q != 16'hFFFF)) begin
                d_fill_cnt_q <= d_fill_cnt_q + 16'd1;
            end
        end
    end

    assign i_fill_cnt = i_fill_cnt_q;
    assign d_fill_cnt = d_fill_cnt_q;
`endif

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Shared-memory arbiter and block-fill engine between the I-cache/D-cache arrays and the single-port multicycle main memory. It sits directly downstream of the pipeline's cache requests: it accepts I-miss, D-miss and D write-through requests and serialises them onto one memory port. For misses it streams a full block back into the owning cache's data array and signals completion, so the pipeline can drop its IF/MEM stall.

## Interface
- BLK_WORDS, 8: 16-bit words per cache block; power of two ≥ 2; WIDX_W = log2(BLK_WORDS).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_miss  in  1  I-cache miss request; held until i_fill_done.
- i_miss_addr  in  16  byte address of the missing instruction.
- d_miss  in  1  D-cache miss request; held until d_fill_done.
- d_miss_addr  in  16  byte address of the missing data.
- d_wr_req  in  1  D-side write-through request; held until d_wr_done.
- d_wr_addr  in  16  write byte address.
- d_wr_data  in  16  write data.
- mem_en  out  1  memory request strobe, one request per cycle.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  mem_rdata valid; returns in issue order.
- fill_data  out  16  word being written into a cache data array.
- fill_widx  out  WIDX_W  word index within the block for fill_data.
- i_fill_we / d_fill_we  out  1  data-array write enable for the I-/D-cache.
- i_fill_done / d_fill_done  out  1  one-cycle pulse: block complete, write tag/valid now.
- d_wr_done  out  1  one-cycle pulse: write accepted by memory.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE: priority d_wr_req > d_miss > i_miss. Winner latched (owner bit, base = addr[15:log2(2·BLK_WORDS)] with offset bits cleared). Write → WRITE; miss → FILL; nothing → IDLE.
- WRITE, one cycle: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_done=1. Next state IDLE.
- FILL: issue counter iss (0..BLK_WORDS) and receive counter rcv (0..BLK_WORDS-1), both zero on entry.
  - While iss < BLK_WORDS: mem_en=1, mem_wr=0, mem_addr = base | (iss<<1); iss++ each cycle.
  - On mem_rvalid: fill_data=mem_rdata, fill_widx=rcv, owner's *_fill_we=1, rcv++.
  - On mem_rvalid with rcv == BLK_WORDS-1: next state DONE.
- DONE, one cycle: owner's *_fill_done=1. Next state IDLE.
- Requesters deassert in the cycle after their done pulse. The IDLE cycle after DONE/WRITE re-arbitrates, so each grant costs at least one idle cycle.
- mem_rvalid outside FILL is ignored. Any mem_rvalid beyond BLK_WORDS is ignored.
- Fill addresses ignore the low offset bits of the request address. The block is always filled word 0 first.
- Reset mid-operation: state → IDLE, counters cleared, partial fill abandoned, no done pulse. The memory shares rst, so no stale read data returns after reset.

## Timing
- Reset values: every output 0; busy 0.
- Outputs mem_* and *_fill_we / fill_data are combinational from state/counters/mem_rvalid; no registered output delay.
- Write: request seen in IDLE at cycle 0, memory write and d_wr_done at cycle 1, IDLE at cycle 2.
- Miss with memory latency L (rvalid L cycles after issue):
  - Issue cycles 1..BLK_WORDS.
  - Fill-writes at cycles 1+L .. BLK_WORDS+L.
  - Done pulse at BLK_WORDS+L+1.
  - With L=4 and BLK_WORDS=8: issues at cycles 1–8, fill writes at 5–12, done at 13.
- Simultaneous d_miss and i_miss: D is served first. The I request waits, held, and is granted in the IDLE cycle after d_fill_done.
- A d_wr_req arriving during an I fill waits until the fill is done.

## Configuration
- MEM_FILL_ARBITER_STATS_EN defined: adds outputs i_fill_cnt and d_fill_cnt, 16 bits each.
  - Each counter increments on its *_fill_done pulse.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then idle → all outputs 0, busy 0. Assert rst during FILL at cycle 6 → next edge IDLE, no fill_done, no further fill_we.
- d_wr_req, addr 16'h0A12, data 16'hBEEF → cycle 1: mem_en=1, mem_wr=1, addr 0A12, wdata BEEF, d_wr_done=1. Cycle 2: busy=0.
- i_miss at 16'h004A, L=4 → reads at 0040, 0042, …, 004E in cycles 1–8. i_fill_we cycles 5–12 with fill_widx 0–7 carrying memory contents. i_fill_done at cycle 13. d_fill_we never asserts.
- d_miss 16'h2006 and i_miss 16'h1000 raised together → D block 2000–200E filled first, d_fill_done at 13. I-fill issues begin at cycle 15, i_fill_done at 27.
- Spurious mem_rvalid while IDLE, plus a 9th rvalid in a fill → no fill_we, counters unchanged.
- With MEM_FILL_ARBITER_STATS_EN: 3 D fills and 2 I fills → d_fill_cnt=3, i_fill_cnt=2. Preload the counter to FFFF, then one more fill → stays FFFF.
